// File: rtl/lut_table_loader_pkg.sv
// Shared types and sizing helpers for the truth-table loader.
// BEATS is the number of config beats per table, and EPB is the number of
// table entries carried by one beat.
package lut_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } lut_state_t;

  function automatic int calc_epb(input int out_bits, input int word_w);
    return word_w / out_bits;
  endfunction

  function automatic int calc_beats(input int in_bits, input int out_bits, input int word_w);
    return ((1 << in_bits) * out_bits) / word_w;
  endfunction

  function automatic int calc_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

  localparam int BEATS_DEF = calc_beats(6, 1, 8);
  localparam int CNT_W_DEF = calc_cnt_w(BEATS_DEF);

endpackage

// File: rtl/lut_table_loader_if.sv
// Config stream and lookup bus of the truth-table loader.
// The master side drives beats and lookups; the slave side is the loader.
interface lut_table_loader_if #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 8
);
  logic                cfg_start;
  logic [WORD_W-1:0]   cfg_data;
  logic                cfg_valid;
  logic                cfg_ready;
  logic                cfg_done;
  logic                cfg_err;
  logic                busy;
  logic                tbl_valid;
  logic                lk_valid;
  logic [IN_BITS-1:0]  lk_addr;
  logic [OUT_BITS-1:0] lk_data;
  logic                lk_data_valid;

  modport master (
    output cfg_start, cfg_data, cfg_valid, lk_valid, lk_addr,
    input  cfg_ready, cfg_done, cfg_err, busy, tbl_valid, lk_data, lk_data_valid
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid, lk_valid, lk_addr,
    output cfg_ready, cfg_done, cfg_err, busy, tbl_valid, lk_data, lk_data_valid
  );
endinterface

// File: rtl/lut_table_loader_dp_bank.sv
// Double-buffered distributed LUT RAM: two DEPTH x OUT_BITS banks.
// The write port stores one whole beat (EPB consecutive entries) per cycle.
// The read port is registered. The loader only ever writes the shadow bank
// and reads the active bank, so reads and writes never collide.
module lut_dp_bank import lut_loader_pkg::*; #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 8
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic                wbank_i,
  input  logic [IN_BITS-1:0]  waddr_i,
  input  logic [WORD_W-1:0]   wdata_i,
  input  logic                rbank_i,
  input  logic [IN_BITS-1:0]  raddr_i,
  output logic [OUT_BITS-1:0] rdata_o
);
  localparam int DEPTH = 1 << IN_BITS;
  localparam int EPB   = calc_epb(OUT_BITS, WORD_W);

  logic [OUT_BITS-1:0] mem_q [2][DEPTH];
  logic [OUT_BITS-1:0] rdata_q;

  // Beat write: entry waddr+i takes slice i of the beat, LSB first.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < EPB; i++) begin
        mem_q[wbank_i][waddr_i + IN_BITS'(i)] <= wdata_i[i*OUT_BITS +: OUT_BITS];
      end
    end
  end

  // Registered read of the requested bank.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[rbank_i][raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_table_loader.sv
// Runtime loader for a LogicNets-style truth-table neuron. Beats stream into
// the shadow bank; a one-cycle COMMIT swaps banks so lookups never see a
// partially written table. Lookups are served from the active bank in every state.
// Optional build macro LUT_LOAD_PARITY_EN: after the last table beat, one extra
// beat must carry the XOR of all loaded table bits in bit 0. If it does not
// match, the load fails with cfg_err and no bank swap.
module lut_table_loader import lut_loader_pkg::*; #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  lut_table_loader_if.slave   bus
);
  localparam int BEATS = calc_beats(IN_BITS, OUT_BITS, WORD_W);
  localparam int EPB   = calc_epb(OUT_BITS, WORD_W);
  localparam int CNT_W = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  lut_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                active_q;
  logic                tbl_valid_q;
  logic                cfg_ready_q;
  logic                cfg_done_q;
  logic                cfg_err_q;
  logic                busy_q;
  logic                lk_dv_q;
  logic                lk_en_q;
`ifdef LUT_LOAD_PARITY_EN
  logic                parity_q;
`endif

  logic                beat_xfer;
  logic                shadow_we;
  logic [IN_BITS-1:0]  shadow_addr;
  logic [OUT_BITS-1:0] rdata;

  // A beat moves on valid&ready. A restart in the same cycle discards it.
  assign beat_xfer   = bus.cfg_valid & cfg_ready_q;
  assign shadow_we   = beat_xfer & (state_q == ST_LOAD) & ~bus.cfg_start;
  assign shadow_addr = IN_BITS'(cnt_q * EPB);

  lut_dp_bank #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .WORD_W   (WORD_W)
  ) u_bank (
    .clk     (clk),
    .we_i    (shadow_we),
    .wbank_i (~active_q),
    .waddr_i (shadow_addr),
    .wdata_i (bus.cfg_data),
    .rbank_i (active_q),
    .raddr_i (bus.lk_addr),
    .rdata_o (rdata)
  );

  // Load/commit FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      tbl_valid_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LUT_LOAD_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_start) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef LUT_LOAD_PARITY_EN
            parity_q    <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (bus.cfg_start) begin
            // Restart: drop the partial shadow contents and begin again.
            cfg_err_q <= 1'b1;
            cnt_q     <= '0;
`ifdef LUT_LOAD_PARITY_EN
            parity_q  <= 1'b0;
`endif
          end else if (beat_xfer) begin
`ifdef LUT_LOAD_PARITY_EN
            parity_q <= parity_q ^ (^bus.cfg_data);
`endif
            if (cnt_q == LAST_BEAT) begin
              cnt_q <= '0;
`ifdef LUT_LOAD_PARITY_EN
              state_q     <= ST_CHECK;
`else
              state_q     <= ST_COMMIT;
              cfg_ready_q <= 1'b0;
              cfg_done_q  <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef LUT_LOAD_PARITY_EN
        ST_CHECK: begin
          if (bus.cfg_start) begin
            state_q   <= ST_LOAD;
            cfg_err_q <= 1'b1;
            cnt_q     <= '0;
            parity_q  <= 1'b0;
          end else if (beat_xfer) begin
            cfg_ready_q <= 1'b0;
            if (bus.cfg_data[0] == parity_q) begin
              state_q    <= ST_COMMIT;
              cfg_done_q <= 1'b1;
            end else begin
              state_q   <= ST_IDLE;
              cfg_err_q <= 1'b1;
              busy_q    <= 1'b0;
            end
          end
        end
`endif
        ST_COMMIT: begin
          // The swap lands on this edge, so a lookup sampled here reads the old bank.
          active_q    <= ~active_q;
          tbl_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          cfg_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Lookup side: delay the valid, and mask the data until a table exists.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_dv_q <= 1'b0;
      lk_en_q <= 1'b0;
    end else begin
      lk_dv_q <= bus.lk_valid;
      lk_en_q <= tbl_valid_q;
    end
  end

  assign bus.cfg_ready     = cfg_ready_q;
  assign bus.cfg_done      = cfg_done_q;
  assign bus.cfg_err       = cfg_err_q;
  assign bus.busy          = busy_q;
  assign bus.tbl_valid     = tbl_valid_q;
  assign bus.lk_data_valid = lk_dv_q;
  assign bus.lk_data       = lk_en_q ? rdata : '0;

endmodule

// File: tb/tb_lut_table_loader.sv
// Self-checking bench for lut_table_loader. Lookups go into a scoreboard
// queue when they are issued. The expected value is taken from the bench's
// own table model, and the queue is drained when lk_data_valid returns.
module tb_lut_table_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_table_loader_if #(.IN_BITS(6), .OUT_BITS(1), .WORD_W(8)) bus ();

  lut_table_loader #(.IN_BITS(6), .OUT_BITS(1), .WORD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          acc_done = 0;
  int          acc_err = 0;
  logic        exp_q[$];
  logic        exp_v;
  logic [63:0] m_act = '0;
  bit          m_valid = 1'b0;

  localparam logic [63:0] TBL1 = {8'h7E, 8'h81, 8'hF0, 8'h0F, 8'h55, 8'hAA, 8'h00, 8'hFF};
  localparam logic [63:0] TBL2 = {TBL1[31:0], TBL1[63:32]};
  logic [63:0] tbl3;

  // Scoreboard drain: every returned lookup must match the oldest pending one.
  always @(negedge clk) begin
    if (bus.lk_data_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL lk_unexpected: lk_data_valid=1 with no lookup pending at %0t", $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.lk_data !== exp_v) begin
          n_fail++;
          $display("FAIL lk_data: got %b want %b at %0t", bus.lk_data, exp_v, $time);
        end
      end
    end
  end

  task automatic step(input bit st, input bit v, input logic [7:0] d, input bit lkv, input logic [5:0] la);
    bus.cfg_start = st;
    bus.cfg_valid = v;
    bus.cfg_data  = d;
    bus.lk_valid  = lkv;
    bus.lk_addr   = la;
    if (lkv) exp_q.push_back(m_valid ? m_act[la] : 1'b0);
    @(posedge clk);
    #1;
    acc_done += (bus.cfg_done === 1'b1) ? 1 : 0;
    acc_err  += (bus.cfg_err === 1'b1) ? 1 : 0;
  endtask

  function automatic logic [5:0] pick(input int mode, input logic [5:0] a);
    return (mode == 2) ? 6'($urandom_range(0, 63)) : a;
  endfunction

  // Drives a complete load (optionally without the start pulse, if already in LOAD).
  task automatic run_load(input logic [63:0] tbl, input bit in_load, input int gap_at,
                          input int gap_len, input int lk_mode, input logic [5:0] lk_a,
                          input bit par_bit, input bit exp_commit,
                          output int n_done, output int n_err, output bit done_on_time,
                          output bit rdy_commit);
    acc_done = 0;
    acc_err  = 0;
    if (!in_load) step(1'b1, 1'b0, 8'h00, lk_mode != 0, pick(lk_mode, lk_a));
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++)
          step(1'b0, 1'b0, 8'($urandom), lk_mode != 0, pick(lk_mode, lk_a));
      end
      step(1'b0, 1'b1, tbl[k*8 +: 8], lk_mode != 0, pick(lk_mode, lk_a));
    end
`ifdef LUT_LOAD_PARITY_EN
    step(1'b0, 1'b1, {7'($urandom), par_bit}, lk_mode != 0, pick(lk_mode, lk_a));
`else
    if (par_bit !== ^tbl) $display("note: parity argument unused in this build");
`endif
    done_on_time = (bus.cfg_done === 1'b1);
    rdy_commit   = (bus.cfg_ready === 1'b1);
    step(1'b0, 1'b0, 8'h00, lk_mode != 0, pick(lk_mode, lk_a));
    if (exp_commit) begin
      m_act   = tbl;
      m_valid = 1'b1;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, lk_mode != 0, pick(lk_mode, lk_a));
    n_done = acc_done;
    n_err  = acc_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'h00);
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.cfg_ready); end
    n_cmp++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.cfg_done); end
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.cfg_err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.tbl_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tbl_valid: got %b want 0", bus.tbl_valid); end
    n_cmp++; if (bus.lk_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_lk_dv: got %b want 0", bus.lk_data_valid); end
    n_cmp++; if (bus.lk_data !== 1'b0) begin n_fail++; $display("FAIL rst_lk_data: got %b want 0", bus.lk_data); end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1, 6'h15);
    n_cmp++; if (bus.lk_data_valid !== 1'b1) begin n_fail++; $display("FAIL rst_lookup_dv: got %b want 1", bus.lk_data_valid); end
    n_cmp++; if (bus.lk_data !== 1'b0) begin n_fail++; $display("FAIL rst_lookup_data: got %b want 0", bus.lk_data); end
    n_cmp++; if (bus.tbl_valid !== 1'b0) begin n_fail++; $display("FAIL rst_lookup_tv: got %b want 0", bus.tbl_valid); end
  endtask

  task automatic test_full_load();
    int nd, ne; bit on_time, rdy;
    logic [5:0] addrs [4];
    logic       wants [4];
    addrs = '{6'd0, 6'd8, 6'd17, 6'd63};
    wants = '{1'b1, 1'b0, 1'b1, 1'b0};
    run_load(TBL1, 1'b0, -1, 0, 2, 6'h00, ^TBL1, 1'b1, nd, ne, on_time, rdy);
    n_cmp++; if (nd != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", nd); end
    n_cmp++; if (ne != 0) begin n_fail++; $display("FAIL full_err_count: got %0d want 0", ne); end
    n_cmp++; if (!on_time) begin n_fail++; $display("FAIL full_done_latency: got late want one cycle after last beat"); end
    n_cmp++; if (rdy) begin n_fail++; $display("FAIL full_ready_commit: got 1 want 0"); end
    n_cmp++; if (bus.tbl_valid !== 1'b1) begin n_fail++; $display("FAIL full_tbl_valid: got %b want 1", bus.tbl_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %b want 0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, addrs[i]);
      n_cmp++;
      if (bus.lk_data !== wants[i]) begin
        n_fail++; $display("FAIL full_lookup_%0d: got %b want %b", addrs[i], bus.lk_data, wants[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int nd, ne; bit on_time, rdy;
    acc_done = 0; acc_err = 0;
    step(1'b1, 1'b0, 8'h00, 1'b1, 6'd17);
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_load: got %b want 1", bus.cfg_ready); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy_load: got %b want 1", bus.busy); end
    run_load(TBL1, 1'b1, 4, 5, 2, 6'h00, ^TBL1, 1'b1, nd, ne, on_time, rdy);
    n_cmp++; if (nd != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", nd); end
    n_cmp++; if (ne != 0) begin n_fail++; $display("FAIL bp_err_count: got %0d want 0", ne); end
    n_cmp++; if (!on_time) begin n_fail++; $display("FAIL bp_done_latency: got late want one cycle after last beat"); end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 6'($urandom_range(0, 63)));
  endtask

  task automatic test_abort();
    int nd, ne; bit on_time, rdy;
    step(1'b1, 1'b0, 8'h00, 1'b1, 6'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, TBL2[k*8 +: 8], 1'b1, 6'd0);
    run_load('0, 1'b0, -1, 0, 1, 6'd0, 1'b0, 1'b1, nd, ne, on_time, rdy);
    n_cmp++; if (ne != 1) begin n_fail++; $display("FAIL abort_err_count: got %0d want 1", ne); end
    n_cmp++; if (nd != 1) begin n_fail++; $display("FAIL abort_done_count: got %0d want 1", nd); end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 6'($urandom_range(0, 63)));
  endtask

  task automatic test_atomic();
    int nd, ne; bit on_time, rdy;
    run_load(TBL2, 1'b0, -1, 0, 1, 6'd0, ^TBL2, 1'b1, nd, ne, on_time, rdy);
    n_cmp++; if (nd != 1) begin n_fail++; $display("FAIL atomic_done_count: got %0d want 1", nd); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 6'd0);
    n_cmp++; if (bus.lk_data !== 1'b1) begin n_fail++; $display("FAIL atomic_new_value: got %b want 1", bus.lk_data); end
  endtask

  task automatic test_restart_final();
    int nd, ne; bit on_time, rdy;
    step(1'b1, 1'b0, 8'h00, 1'b1, 6'd5);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, TBL1[k*8 +: 8], 1'b1, 6'($urandom_range(0, 63)));
    step(1'b1, 1'b1, TBL1[63:56], 1'b1, 6'd0);
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL restart_err: got %b want 1", bus.cfg_err); end
    n_cmp++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL restart_no_done: got %b want 0", bus.cfg_done); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL restart_ready: got %b want 1", bus.cfg_ready); end
    run_load(tbl3, 1'b1, -1, 0, 2, 6'h00, ^tbl3, 1'b1, nd, ne, on_time, rdy);
    n_cmp++; if (nd != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", nd); end
    n_cmp++; if (ne != 0) begin n_fail++; $display("FAIL restart_err_count: got %0d want 0", ne); end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 6'($urandom_range(0, 63)));
  endtask

`ifdef LUT_LOAD_PARITY_EN
  task automatic test_parity_bad();
    int nd, ne; bit on_time, rdy;
    run_load(TBL1, 1'b0, -1, 0, 2, 6'h00, 1'b1, 1'b0, nd, ne, on_time, rdy);
    n_cmp++; if (ne != 1) begin n_fail++; $display("FAIL parity_err_count: got %0d want 1", ne); end
    n_cmp++; if (nd != 0) begin n_fail++; $display("FAIL parity_done_count: got %0d want 0", nd); end
    n_cmp++; if (bus.tbl_valid !== 1'b1) begin n_fail++; $display("FAIL parity_tbl_valid: got %b want 1", bus.tbl_valid); end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 6'($urandom_range(0, 63)));
  endtask
`endif

  task automatic test_reset_midload();
    step(1'b1, 1'b0, 8'h00, 1'b0, 6'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, TBL1[k*8 +: 8], 1'b0, 6'd0);
    rst_n = 1'b0;
    step(1'b0, 1'b1, TBL1[31:24], 1'b0, 6'd0);
    rst_n = 1'b1;
    m_valid = 1'b0;
    n_cmp++; if (bus.tbl_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_tbl_valid: got %b want 0", bus.tbl_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", bus.cfg_ready); end
    step(1'b0, 1'b1, 8'hFF, 1'b1, 6'd0);
    n_cmp++; if (bus.lk_data !== 1'b0) begin n_fail++; $display("FAIL midrst_lookup: got %b want 0", bus.lk_data); end
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ignore_valid: got %b want 0", bus.cfg_ready); end
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.lk_valid  = 1'b0;
    bus.lk_addr   = '0;
    tbl3 = {$urandom, $urandom};
    test_reset();
    test_full_load();
    test_backpressure();
    test_abort();
    test_atomic();
    test_restart_final();
`ifdef LUT_LOAD_PARITY_EN
    test_parity_bad();
`endif
    test_reset_midload();
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL lk_pending: got %0d lookups outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
